// File: rtl/hqvga_vga_gen_if.sv
// rtl/hqvga_vga_gen_if.sv - HQVGA source-side bundle: framebuffer read port, video outputs, CPU status
interface hqvga_vga_gen_if;
  logic [14:0] O_fb_addr;
  logic [7:0]  I_fb_rdata;
  logic        O_hqvga_de;
  logic        O_hqvga_hs;
  logic        O_hqvga_vs;
  logic [2:0]  O_hqvga_r;
  logic [2:0]  O_hqvga_g;
  logic [1:0]  O_hqvga_b;
  logic        O_vblank;
  logic        O_frame_start;

  modport master (
    output O_fb_addr,
    input  I_fb_rdata,
    output O_hqvga_de, O_hqvga_hs, O_hqvga_vs,
    output O_hqvga_r, O_hqvga_g, O_hqvga_b,
    output O_vblank, O_frame_start
  );

  modport slave (
    input  O_fb_addr,
    output I_fb_rdata,
    input  O_hqvga_de, O_hqvga_hs, O_hqvga_vs,
    input  O_hqvga_r, O_hqvga_g, O_hqvga_b,
    input  O_vblank, O_frame_start
  );
endinterface

// File: rtl/hqvga_vga_gen.sv
// rtl/hqvga_vga_gen.sv - 800x600@72 VGA timing generator, 5x replicated 160x120 RGB332 framebuffer readout
// Macro HQVGA_TESTPAT_EN replaces framebuffer colour with 8 vertical colour bars.
module hqvga_vga_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FPORCH = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BPORCH = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FPORCH = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BPORCH = 23,
  parameter int SRC_W    = 160,
  parameter int SCALE    = 5
) (
  input logic             I_hqvga_clk,
  input logic             I_rst,
  hqvga_vga_gen_if.master vga
);
  localparam int H_TOTAL  = H_ACTIVE + H_FPORCH + H_SYNC + H_BPORCH;
  localparam int V_TOTAL  = V_ACTIVE + V_FPORCH + V_SYNC + V_BPORCH;
  localparam int HS_FIRST = H_ACTIVE + H_FPORCH;
  localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
  localparam int VS_FIRST = V_ACTIVE + V_FPORCH;
  localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;

  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic [2:0]  hsub, vsub;
  logic [7:0]  src_x;
  logic [14:0] line_base;
  logic [1:0]  de_dly, hs_dly, vs_dly;
  logic [7:0]  pix;

  logic h_last, v_last, h_act, v_act, active, hs_raw, vs_raw;
  assign h_last = (h_cnt == 11'(H_TOTAL - 1));
  assign v_last = (v_cnt == 10'(V_TOTAL - 1));
  assign h_act  = (h_cnt < 11'(H_ACTIVE));
  assign v_act  = (v_cnt < 10'(V_ACTIVE));
  assign active = h_act && v_act;
  assign hs_raw = (h_cnt >= 11'(HS_FIRST)) && (h_cnt <= 11'(HS_LAST));
  assign vs_raw = (v_cnt >= 10'(VS_FIRST)) && (v_cnt <= 10'(VS_LAST));

  // Undelayed status for the CPU side; gated so it reads 0 while held in reset.
  assign vga.O_vblank      = !v_act;
  assign vga.O_frame_start = (h_cnt == 11'd0) && (v_cnt == 10'd0) && !I_rst;

  always_ff @(posedge I_hqvga_clk or posedge I_rst) begin
    if (I_rst) begin
      h_cnt          <= '0;
      v_cnt          <= '0;
      hsub           <= '0;
      vsub           <= '0;
      src_x          <= '0;
      line_base      <= '0;
      de_dly         <= '0;
      hs_dly         <= '0;
      vs_dly         <= '0;
      vga.O_fb_addr  <= '0;
      vga.O_hqvga_de <= 1'b0;
      vga.O_hqvga_hs <= 1'b0;
      vga.O_hqvga_vs <= 1'b0;
      vga.O_hqvga_r  <= '0;
      vga.O_hqvga_g  <= '0;
      vga.O_hqvga_b  <= '0;
    end else begin
      h_cnt <= h_last ? 11'd0 : h_cnt + 11'd1;
      if (h_last) v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;

      if (h_last) begin
        hsub  <= '0;
        src_x <= '0;
      end else if (h_act) begin
        if (hsub == 3'(SCALE - 1)) begin
          hsub  <= '0;
          src_x <= src_x + 8'd1;
        end else begin
          hsub <= hsub + 3'd1;
        end
      end

      // line_base steps one source row after every SCALE output lines.
      if (h_last && v_last) begin
        vsub      <= '0;
        line_base <= '0;
      end else if (h_last && v_act) begin
        if (vsub == 3'(SCALE - 1)) begin
          vsub      <= '0;
          line_base <= line_base + 15'(SRC_W);
        end else begin
          vsub <= vsub + 3'd1;
        end
      end

      if (active) vga.O_fb_addr <= line_base + 15'(src_x);

      de_dly <= {de_dly[0], active};
      hs_dly <= {hs_dly[0], hs_raw};
      vs_dly <= {vs_dly[0], vs_raw};
      vga.O_hqvga_de <= de_dly[1];
      vga.O_hqvga_hs <= hs_dly[1];
      vga.O_hqvga_vs <= vs_dly[1];
      vga.O_hqvga_r  <= de_dly[1] ? pix[7:5] : 3'd0;
      vga.O_hqvga_g  <= de_dly[1] ? pix[4:2] : 3'd0;
      vga.O_hqvga_b  <= de_dly[1] ? pix[1:0] : 2'd0;
    end
  end

`ifdef HQVGA_TESTPAT_EN
  localparam int BAR_W = (SRC_W / 8) * SCALE;

  logic [6:0] bar_sub;
  logic [2:0] bar_idx;
  logic [7:0] bar_color, bar_d1, bar_d2;

  always_comb begin
    bar_color = 8'h00;
    case (bar_idx)
      3'd0: bar_color = 8'hFF;
      3'd1: bar_color = 8'hFC;
      3'd2: bar_color = 8'h1F;
      3'd3: bar_color = 8'h1C;
      3'd4: bar_color = 8'hE3;
      3'd5: bar_color = 8'hE0;
      3'd6: bar_color = 8'h03;
      3'd7: bar_color = 8'h00;
      default: bar_color = 8'h00;
    endcase
  end

  // Two register stages put the bar colour where the RAM data would be.
  always_ff @(posedge I_hqvga_clk or posedge I_rst) begin
    if (I_rst) begin
      bar_sub <= '0;
      bar_idx <= '0;
      bar_d1  <= '0;
      bar_d2  <= '0;
    end else begin
      if (h_last) begin
        bar_sub <= '0;
        bar_idx <= '0;
      end else if (h_act) begin
        if (bar_sub == 7'(BAR_W - 1)) begin
          bar_sub <= '0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_sub <= bar_sub + 7'd1;
        end
      end
      bar_d1 <= bar_color;
      bar_d2 <= bar_d1;
    end
  end

  assign pix = bar_d2;
`else
  assign pix = vga.I_fb_rdata;
`endif
endmodule
